bid_arbiter: RTL and testbench

//  Auction arbiter that sits directly upstream of the per-bidder bank blocks.
//  - Collects one bid per bidder and checks each bid against that bidder's current bank balance.
//  - Picks the highest affordable bid, using round-robin tie-break.
//  - Drives a one-cycle one-hot 'granted' pulse; each bank consumes its bit to debit the bid.
//  - One auction per 3 clocks; granted is registered so banks sample a stable level at negedge clk.

---
 rtl/bid_arbiter_if.sv | 29 ++
 rtl/bid_arbiter.sv | 144 ++++++++++++++
 tb/tb_bid_arbiter.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/bid_arbiter_if.sv
// Handshake/bus bundle between the auction controller and the bid_arbiter.
// The master side issues bids and start requests; the slave side is the arbiter.
interface bid_arbiter_if #(
    parameter int N_BIDDERS = 4,
    parameter int BID_W     = 4,
    parameter int BAL_W     = 10,
    parameter int ID_W      = 2
);
    logic                       start;
    logic [N_BIDDERS*BID_W-1:0] bid;
    logic [N_BIDDERS-1:0]       bid_valid;
    logic [N_BIDDERS*BAL_W-1:0] balance;
    logic                       busy;
    logic [N_BIDDERS-1:0]       granted;
    logic                       done;
    logic                       no_winner;
    logic [ID_W-1:0]            win_id;
    logic [BID_W-1:0]           win_bid;

    modport master (
        output start, bid, bid_valid, balance,
        input  busy, granted, done, no_winner, win_id, win_bid
    );

    modport slave (
        input  start, bid, bid_valid, balance,
        output busy, granted, done, no_winner, win_id, win_bid
    );
endinterface

// File: rtl/bid_arbiter.sv
// Auction arbiter: latches one bid per bidder, awards the highest affordable bid
// with round-robin tie-break, and emits a registered one-cycle one-hot grant.
module bid_arbiter #(
    parameter int N_BIDDERS = 4,
    parameter int BID_W     = 4,
    parameter int BAL_W     = 10,
    parameter int ID_W      = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    bid_arbiter_if.slave    bus
);

    typedef enum logic [1:0] {S_IDLE, S_EVAL, S_GRANT} state_e;

    state_e               state_q, state_d;
    logic [BID_W-1:0]     bid_q [N_BIDDERS];
    logic [BID_W-1:0]     bid_d [N_BIDDERS];
    logic [BAL_W-1:0]     bal_q [N_BIDDERS];
    logic [BAL_W-1:0]     bal_d [N_BIDDERS];
    logic [N_BIDDERS-1:0] valid_q, valid_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                 busy_q, busy_d;
    logic [N_BIDDERS-1:0] granted_q, granted_d;
    logic                 done_q, done_d;
    logic                 no_winner_q, no_winner_d;
    logic [ID_W-1:0]      win_id_q, win_id_d;
    logic [BID_W-1:0]     win_bid_q, win_bid_d;

    logic [BID_W-1:0]     in_bid [N_BIDDERS];
    logic [BAL_W-1:0]     in_bal [N_BIDDERS];
    logic [N_BIDDERS-1:0] elig;
    logic [ID_W:0]        scan_sum;
    logic [ID_W-1:0]      scan_idx;
    logic                 found;
    logic [ID_W-1:0]      best_id;
    logic [BID_W-1:0]     best_bid;

    for (genvar g = 0; g < N_BIDDERS; g++) begin : g_unpack
        assign in_bid[g] = bus.bid[g*BID_W +: BID_W];
        assign in_bal[g] = bus.balance[g*BAL_W +: BAL_W];
        // Balance must strictly exceed the bid so a bank is never debited to zero.
        assign elig[g]   = valid_q[g] && (bid_q[g] != '0) &&
                           (bal_q[g] > BAL_W'(bid_q[g]));
    end

    // Scan starting at rr_ptr; strict '>' keeps the earliest bidder on ties.
    always_comb begin
        found    = 1'b0;
        best_id  = '0;
        best_bid = '0;
        scan_sum = '0;
        scan_idx = '0;
        for (int k = 0; k < N_BIDDERS; k++) begin
            scan_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_sum >= (ID_W+1)'(N_BIDDERS)) begin
                scan_sum = scan_sum - (ID_W+1)'(N_BIDDERS);
            end
            scan_idx = scan_sum[ID_W-1:0];
            if (elig[scan_idx] && (!found || (bid_q[scan_idx] > best_bid))) begin
                found    = 1'b1;
                best_id  = scan_idx;
                best_bid = bid_q[scan_idx];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        bid_d       = bid_q;
        bal_d       = bal_q;
        valid_d     = valid_q;
        rr_ptr_d    = rr_ptr_q;
        granted_d   = '0;
        done_d      = 1'b0;
        no_winner_d = 1'b0;
        win_id_d    = '0;
        win_bid_d   = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    bid_d   = in_bid;
                    bal_d   = in_bal;
                    valid_d = bus.bid_valid;
                    state_d = S_EVAL;
                end
            end
            S_EVAL: begin
                state_d     = S_GRANT;
                done_d      = 1'b1;
                no_winner_d = !found;
                if (found) begin
                    granted_d = N_BIDDERS'(1) << best_id;
                    win_id_d  = best_id;
                    win_bid_d = best_bid;
                    rr_ptr_d  = (best_id == ID_W'(N_BIDDERS-1)) ? '0 : best_id + ID_W'(1);
                end
            end
            S_GRANT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            bid_q       <= '{default: '0};
            bal_q       <= '{default: '0};
            valid_q     <= '0;
            rr_ptr_q    <= '0;
            busy_q      <= 1'b0;
            granted_q   <= '0;
            done_q      <= 1'b0;
            no_winner_q <= 1'b0;
            win_id_q    <= '0;
            win_bid_q   <= '0;
        end else begin
            state_q     <= state_d;
            bid_q       <= bid_d;
            bal_q       <= bal_d;
            valid_q     <= valid_d;
            rr_ptr_q    <= rr_ptr_d;
            busy_q      <= busy_d;
            granted_q   <= granted_d;
            done_q      <= done_d;
            no_winner_q <= no_winner_d;
            win_id_q    <= win_id_d;
            win_bid_q   <= win_bid_d;
        end
    end

    assign bus.busy      = busy_q;
    assign bus.granted   = granted_q;
    assign bus.done      = done_q;
    assign bus.no_winner = no_winner_q;
    assign bus.win_id    = win_id_q;
    assign bus.win_bid   = win_bid_q;

endmodule

// File: tb/tb_bid_arbiter.sv
// Bench for bid_arbiter: directed auctions plus randomized ones, each checked
// against an auction model that ranks eligible bids by value and ring distance.
module tb_bid_arbiter;
    localparam int N  = 4;
    localparam int BW = 4;
    localparam int LW = 10;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    bid_arbiter_if #(.N_BIDDERS(N), .BID_W(BW), .BAL_W(LW), .ID_W(IW)) bus ();

    bid_arbiter #(.N_BIDDERS(N), .BID_W(BW), .BAL_W(LW), .ID_W(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    int m_rr;
    int m_bid [N];
    bit m_val [N];
    int m_bal [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Winner = eligible bidder with the largest bid; equal bids go to the one
    // nearest the round-robin pointer going upward around the ring.
    function automatic int model_winner();
        int best = -1;
        for (int i = 0; i < N; i++) begin
            if (m_val[i] && m_bid[i] != 0 && m_bal[i] > m_bid[i]) begin
                if (best < 0 || m_bid[i] > m_bid[best] ||
                    (m_bid[i] == m_bid[best] &&
                     ((i - m_rr + N) % N) < ((best - m_rr + N) % N)))
                    best = i;
            end
        end
        return best;
    endfunction

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            bus.bid[i*BW +: BW]       = BW'(m_bid[i]);
            bus.bid_valid[i]          = m_val[i];
            bus.balance[i*LW +: LW]   = LW'(m_bal[i]);
        end
    endtask

    task automatic set_case(input int b0, input int b1, input int b2, input int b3,
                            input logic [3:0] vld, input int bal);
        m_bid[0] = b0; m_bid[1] = b1; m_bid[2] = b2; m_bid[3] = b3;
        for (int i = 0; i < N; i++) begin
            m_val[i] = vld[i];
            m_bal[i] = bal;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_granted"},   32'(bus.granted),   32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd0);
        check({tag, "_no_winner"}, 32'(bus.no_winner), 32'd0);
        check({tag, "_win_id"},    32'(bus.win_id),    32'd0);
        check({tag, "_win_bid"},   32'(bus.win_bid),   32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    task automatic run_auction(input string tag, input bit poke_start);
        int exp;
        drive_inputs();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = poke_start;
        // Inputs are scrambled after the latch edge; the result must not change.
        bus.bid       = 16'($urandom);
        bus.bid_valid = 4'($urandom);
        bus.balance   = {8'($urandom), 32'($urandom)};
        check({tag, "_eval_busy"},    32'(bus.busy),    32'd1);
        check({tag, "_eval_granted"}, 32'(bus.granted), 32'd0);
        check({tag, "_eval_done"},    32'(bus.done),    32'd0);
        exp = model_winner();
        @(posedge clk); #1;
        bus.start = 1'b0;
        check({tag, "_granted"},   32'(bus.granted),   (exp >= 0) ? (32'd1 << exp) : 32'd0);
        check({tag, "_done"},      32'(bus.done),      32'd1);
        check({tag, "_no_winner"}, 32'(bus.no_winner), (exp >= 0) ? 32'd0 : 32'd1);
        check({tag, "_win_id"},    32'(bus.win_id),    (exp >= 0) ? 32'(exp) : 32'd0);
        check({tag, "_win_bid"},   32'(bus.win_bid),   (exp >= 0) ? 32'(m_bid[exp]) : 32'd0);
        check({tag, "_grant_busy"}, 32'(bus.busy),     32'd1);
        if (exp >= 0) m_rr = (exp + 1) % N;
        @(posedge clk); #1;
        check_idle_outputs({tag, "_after"});
        if (poke_start) begin
            @(posedge clk); #1;
            check({tag, "_poke_done"}, 32'(bus.done), 32'd0);
            check({tag, "_poke_busy"}, 32'(bus.busy), 32'd0);
        end
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("rst_pulse");
        m_rr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        m_rr          = 0;
        bus.start     = 1'b1;
        bus.bid       = 16'h5A3C;
        bus.bid_valid = 4'hF;
        bus.balance   = '1;
        rst_n         = 1'b0;
        #1;
        check_idle_outputs("rst_imm");
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("rst_held");
        bus.start = 1'b0;
        rst_n     = 1'b1;
        @(posedge clk); #1;
        check_idle_outputs("rst_release");

        // Highest bid wins, first grant two edges after start.
        set_case(3, 7, 5, 2, 4'b1111, 750);
        run_auction("basic", 1'b0);

        // Three-way tie rotates 0 -> 1 -> 3, pointer back to 0.
        pulse_reset();
        set_case(6, 6, 0, 6, 4'b1111, 750);
        run_auction("tie_a", 1'b0);
        run_auction("tie_b", 1'b0);
        run_auction("tie_c", 1'b0);
        check("tie_rr_end", 32'(m_rr), 32'd0);

        // Affordability: bid equal to balance is not eligible.
        set_case(4, 0, 9, 0, 4'b0101, 750);
        m_bal[2] = 9;
        run_auction("afford_eq", 1'b0);
        m_bal[2] = 10;
        run_auction("afford_gt", 1'b0);
        set_case(1, 1, 1, 1, 4'b1111, 1);
        run_auction("bal_one", 1'b0);

        // Nobody bidding, with a stray start during EVAL.
        set_case(5, 6, 7, 8, 4'b0000, 750);
        run_auction("none", 1'b1);

        // Abort while bidder 2 holds the grant.
        set_case(1, 2, 9, 3, 4'b1111, 750);
        drive_inputs();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        check("abort_granted_pre", 32'(bus.granted), 32'b0100);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        m_rr = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        set_case(5, 5, 5, 5, 4'b1111, 750);
        run_auction("post_abort", 1'b0);

        for (int t = 0; t < 60; t++) begin
            int lo;
            lo = ($urandom_range(0, 2) == 0) ? 5 : 0;
            for (int i = 0; i < N; i++) begin
                m_bid[i] = (lo != 0) ? $urandom_range(5, 7) : $urandom_range(0, 15);
                m_val[i] = ($urandom_range(0, 4) != 0);
                case ($urandom_range(0, 4))
                    0: m_bal[i] = 0;
                    1: m_bal[i] = 1;
                    2: m_bal[i] = m_bid[i];
                    3: m_bal[i] = m_bid[i] + 1;
                    default: m_bal[i] = $urandom_range(0, 1023);
                endcase
            end
            run_auction("rand", ($urandom_range(0, 3) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d tests expected completion", n_tests);
        $fatal(1, "timeout");
    end
endmodule
